cam_reg_sequencer: RTL
======================

// Module: cam_reg_sequencer
// PURPOSE
//  Boot-time configuration sequencer for the camera SCCB/IIC driver. Walks an external
//  register table of (reg addr, value) pairs and issues one driver write per entry. Each
//  write is optionally read back and compared. Failed entries are retried. Reports
//  done/error to the top level. Sits between the camera top and the IIC driver, on the
//  driver's clock.
// PARAMETERS
//  NUM_REGS    64      table entries, indices 0..NUM_REGS-1, must be 1..256
//  PWR_WAIT    1000    cycles idled after start before the first transaction
//  DELAY_UNIT  256     cycles per unit of a delay-marker entry
//  TIMEOUT     100     cycles allowed from en pulse to driver completion
//  MAX_RETRY   3       retries per entry after the first attempt
//  VERIFY      1       1 = read back and compare every written entry
// PORTS
//  clk           in   1  driver clock, rising edge
//  rst           in   1  asynchronous reset, active-high
//  start         in   1  one-cycle pulse; ignored unless state IDLE, DONE or ERROR
//  table_idx     out  8  table read index
//  table_addr    in   8  register address at table_idx, combinational ROM
//  table_data    in   8  register value at table_idx, combinational ROM
//  iic_wr_en     out  1  one-cycle write request to driver
//  iic_rd_en     out  1  one-cycle read request to driver
//  iic_addr      out  8  register address; stable from request until completion
//  iic_wr_data   out  8  write value; stable from request until completion
//  iic_rd_data   in   8  driver read result, valid at completion
//  iic_work_done in   1  driver done level; stays high until the next transaction starts
//  iic_ack       in   1  driver ack summary; 0 = all bytes acknowledged
//  busy          out  1  high in every state except IDLE, DONE, ERROR
//  done          out  1  sticky; high when the whole table was written without error
//  error         out  1  sticky; an entry failed after MAX_RETRY retries
//  err_idx       out  8  index of the failing entry, valid while error is high
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; idx, retry and timer counters 0.
//  States and transitions:
//   IDLE   : on start -> PWR; clear done, error, idx.
//   PWR    : count PWR_WAIT cycles -> FETCH.
//   FETCH  : if table_addr==8'hFF (delay marker) -> DLY with table_data*DELAY_UNIT cycles.
//            Otherwise latch addr/data into iic_addr/iic_wr_data and -> WR.
//   WR     : pulse iic_wr_en for exactly 1 cycle -> WWAIT. Never hold en high, or the
//            driver re-triggers.
//   WWAIT  : wait for a rising edge of iic_work_done, edge-detected against a registered
//            copy. The stale high level left over from the previous transaction is not a
//            completion. Success iff iic_ack==0. On success -> RD if VERIFY, else NEXT.
//            On failure -> RETRY.
//   RD     : pulse iic_rd_en for 1 cycle with the same iic_addr -> RWAIT.
//   RWAIT  : on a work_done rising edge, match iff iic_rd_data==iic_wr_data.
//            Match -> NEXT; mismatch -> RETRY. iic_ack is ignored for reads.
//   DLY    : count down -> NEXT. A data value of 0 means 0 cycles.
//   RETRY  : if retry<MAX_RETRY, retry++ -> WR. Otherwise error=1, err_idx=idx -> ERROR.
//   NEXT   : retry=0. If idx==NUM_REGS-1: done=1 -> DONE. Otherwise idx++ -> FETCH.
//   DONE / ERROR : idle; start restarts from IDLE behaviour, skipping IDLE's wait cycle.
//  Timeout: in WWAIT or RWAIT, TIMEOUT cycles without a completion edge count as a
//   failure -> RETRY.
//  Retry counting: the counter covers the whole entry (write plus verify), so an entry
//   gets at most 1+MAX_RETRY attempts.
//  Latency: with VERIFY=0, one entry costs FETCH+WR+driver(~34)+NEXT cycles.
//  Widths: the delay counter is wide enough for 255*DELAY_UNIT. idx never wraps past
//   NUM_REGS-1.
//  Reset mid-transaction: all en outputs drop immediately. The driver owns bus recovery.
//  start while busy: ignored.
//  iic_wr_en and iic_rd_en are never high in the same cycle.
// TESTING
//  T1 NUM_REGS=3, table {12:80, 11:01, 3A:04}, driver model acks and echoes data
//     -> 3 wr + 3 rd pulses, each 1 cycle; done=1; error=0; busy low after.
//  T2 entry 1 returns iic_ack=1 twice, then 0 -> 3 wr pulses for idx 1; done=1.
//  T3 entry 2 always NACKs, MAX_RETRY=3 -> 4 attempts; error=1, err_idx=2, done=0.
//  T4 entry {FF:03}, DELAY_UNIT=256 -> no iic pulse; 768-cycle gap before the next FETCH.
//  T5 model never raises work_done -> en pulse, timeout after TIMEOUT cycles, 4 attempts,
//     then error.
//  T6 assert rst during WWAIT -> en low and outputs 0 at once; start after release
//     reruns from idx 0 after PWR_WAIT.

Source files
------------

// File: rtl/cam_reg_sequencer_if.sv
// Sequencer-to-IIC-driver request/completion bus.
// The master side issues one-cycle requests and the slave side reports completion.
interface cam_reg_sequencer_if;
  logic       iic_wr_en;
  logic       iic_rd_en;
  logic [7:0] iic_addr;
  logic [7:0] iic_wr_data;
  logic [7:0] iic_rd_data;
  logic       iic_work_done;
  logic       iic_ack;

  modport master (
    output iic_wr_en, iic_rd_en, iic_addr, iic_wr_data,
    input  iic_rd_data, iic_work_done, iic_ack
  );

  modport slave (
    input  iic_wr_en, iic_rd_en, iic_addr, iic_wr_data,
    output iic_rd_data, iic_work_done, iic_ack
  );
endinterface

// File: rtl/cam_reg_sequencer.sv
// Boot-time camera register sequencer: walks an (addr, value) table and issues one driver
// write per entry, with optional read-back verify, bounded retries and delay-marker entries.
module cam_reg_sequencer #(
  parameter int NUM_REGS   = 64,
  parameter int PWR_WAIT   = 1000,
  parameter int DELAY_UNIT = 256,
  parameter int TIMEOUT    = 100,
  parameter int MAX_RETRY  = 3,
  parameter int VERIFY     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [7:0]                 table_idx,
  input  logic [7:0]                 table_addr,
  input  logic [7:0]                 table_data,
  cam_reg_sequencer_if.master        iic,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [7:0]                 err_idx
);

  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int T_MAX   = (DLY_MAX > PWR_WAIT) ? ((DLY_MAX > TIMEOUT) ? DLY_MAX : TIMEOUT)
                                                : ((PWR_WAIT > TIMEOUT) ? PWR_WAIT : TIMEOUT);
  localparam int TW      = $clog2(T_MAX + 2);
  localparam int RW      = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] C_PWR     = TW'(PWR_WAIT);
  localparam logic [TW-1:0] C_TIMEOUT = TW'(TIMEOUT);
  localparam logic [RW-1:0] C_MAXR    = RW'(MAX_RETRY);
  localparam logic [7:0]    C_LAST    = 8'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_FETCH, S_WR, S_WWAIT, S_RD, S_RWAIT,
    S_DLY, S_RETRY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retry;
  logic [7:0]    r_idx;
  logic          r_wd_q;
  logic          r_wr_en;
  logic          r_rd_en;
  logic [7:0]    r_addr;
  logic [7:0]    r_wdata;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic [7:0]    r_err_idx;

  logic w_wd_rise;
  logic w_tmo;

  // Only a fresh rising edge is a completion; the level left high by the last job is not.
  assign w_wd_rise = iic.iic_work_done & ~r_wd_q;
  assign w_tmo     = (r_timer >= C_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_retry   <= '0;
      r_idx     <= '0;
      r_wd_q    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_wd_q  <= iic.iic_work_done;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state   <= S_PWR;
            r_timer   <= C_PWR;
            r_idx     <= '0;
            r_retry   <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_err_idx <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_PWR: begin
          if (r_timer <= TW'(1)) begin
            r_timer <= '0;
            r_state <= S_FETCH;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_FETCH: begin
          if (table_addr == 8'hFF) begin
            r_timer <= TW'(int'(table_data) * DELAY_UNIT);
            r_state <= S_DLY;
          end else begin
            r_addr  <= table_addr;
            r_wdata <= table_data;
            r_wr_en <= 1'b1;
            r_state <= S_WR;
          end
        end
        // The request cycle counts toward the timeout window.
        S_WR: begin
          r_timer <= TW'(1);
          r_state <= S_WWAIT;
        end
        S_WWAIT: begin
          if (w_wd_rise) begin
            if (iic.iic_ack) begin
              r_state <= S_RETRY;
            end else if (VERIFY != 0) begin
              r_rd_en <= 1'b1;
              r_state <= S_RD;
            end else begin
              r_state <= S_NEXT;
            end
          end else if (w_tmo) begin
            r_state <= S_RETRY;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RD: begin
          r_timer <= TW'(1);
          r_state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (w_wd_rise) begin
            r_state <= (iic.iic_rd_data == r_wdata) ? S_NEXT : S_RETRY;
          end else if (w_tmo) begin
            r_state <= S_RETRY;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DLY: begin
          if (r_timer == '0) begin
            r_state <= S_NEXT;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        // One retry budget covers both the write and its read-back.
        S_RETRY: begin
          if (r_retry < C_MAXR) begin
            r_retry <= r_retry + RW'(1);
            r_wr_en <= 1'b1;
            r_state <= S_WR;
          end else begin
            r_error   <= 1'b1;
            r_err_idx <= r_idx;
            r_busy    <= 1'b0;
            r_state   <= S_ERROR;
          end
        end
        S_NEXT: begin
          r_retry <= '0;
          if (r_idx == C_LAST) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign table_idx       = r_idx;
  assign iic.iic_wr_en   = r_wr_en;
  assign iic.iic_rd_en   = r_rd_en;
  assign iic.iic_addr    = r_addr;
  assign iic.iic_wr_data = r_wdata;
  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign err_idx         = r_err_idx;

endmodule
